ibex_tsmap_arb: RTL and testbench

Arbiter and sequencer for the single-port TS (revocation-tag) map SRAM behind the core's tsmap_cs_o/tsmap_addr_o/tsmap_rdata_i port. It shares the port between two requesters: the core's load-barrier lookup (port C) and the background revocation engine TBRE (port T). It returns read data and integrity bits to the winning requester. It sits between those two clients and the top-level TS map memory interface, with an anti-starvation guarantee for TBRE and range checking.

---
 rtl/ibex_tsmap_arb_pkg.sv | 18 +
 rtl/ibex_tsmap_arb_if.sv | 47 ++++
 rtl/ibex_tsmap_arb.sv | 90 +++++++++
 tb/tb_ibex_tsmap_arb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_tsmap_arb_pkg.sv
// Shared types for the TS map port arbiter: response owner encoding and the
// registered response tag that steers SRAM read data back to the winner.
package ibex_tsmap_arb_pkg;

    localparam int unsigned StarveCntW = 4;

    typedef enum logic {
        TsOwnCore = 1'b0,
        TsOwnTbre = 1'b1
    } tsmap_owner_e;

    typedef struct packed {
        logic         valid;
        tsmap_owner_e owner;
        logic         err;
    } tsmap_rsp_t;

endpackage

// File: rtl/ibex_tsmap_arb_if.sv
// Bundle of the core lookup port, the TBRE port and the TS map SRAM port.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface ibex_tsmap_arb_if
    import ibex_tsmap_arb_pkg::*;
#(
    parameter int unsigned AddrW = 16
);
    logic                  c_req_i;
    logic [AddrW-1:0]      c_addr_i;
    logic                  c_gnt_o;
    logic                  c_rvalid_o;
    logic [31:0]           c_rdata_o;
    logic [6:0]            c_rdata_intg_o;
    logic                  c_err_o;

    logic                  t_req_i;
    logic [AddrW-1:0]      t_addr_i;
    logic                  t_gnt_o;
    logic                  t_rvalid_o;
    logic [31:0]           t_rdata_o;
    logic [6:0]            t_rdata_intg_o;
    logic                  t_err_o;

    logic                  tsmap_cs_o;
    logic [AddrW-1:0]      tsmap_addr_o;
    logic [31:0]           tsmap_rdata_i;
    logic [6:0]            tsmap_rdata_intg_i;

    logic [StarveCntW-1:0] starve_cnt_o;

    modport slave (
        input  c_req_i, c_addr_i, t_req_i, t_addr_i,
               tsmap_rdata_i, tsmap_rdata_intg_i,
        output c_gnt_o, c_rvalid_o, c_rdata_o, c_rdata_intg_o, c_err_o,
               t_gnt_o, t_rvalid_o, t_rdata_o, t_rdata_intg_o, t_err_o,
               tsmap_cs_o, tsmap_addr_o, starve_cnt_o
    );

    modport master (
        output c_req_i, c_addr_i, t_req_i, t_addr_i,
               tsmap_rdata_i, tsmap_rdata_intg_i,
        input  c_gnt_o, c_rvalid_o, c_rdata_o, c_rdata_intg_o, c_err_o,
               t_gnt_o, t_rvalid_o, t_rdata_o, t_rdata_intg_o, t_err_o,
               tsmap_cs_o, tsmap_addr_o, starve_cnt_o
    );

endinterface

// File: rtl/ibex_tsmap_arb.sv
// Shares the single-port TS map SRAM between core lookups and the TBRE, with
// core priority bounded by a starvation counter and out-of-range error replies.
module ibex_tsmap_arb
    import ibex_tsmap_arb_pkg::*;
#(
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned AddrW     = 16,
    parameter int unsigned MaxStarve = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ibex_tsmap_arb_if.slave  bus
);

    localparam logic [StarveCntW-1:0] MaxCnt   = StarveCntW'(MaxStarve);
    localparam logic [AddrW:0]        MapLimit = (AddrW+1)'(TSMapSize);

    logic                  init_q;
    logic [StarveCntW-1:0] starve_q;
    tsmap_rsp_t            rsp_q;
    logic [AddrW-1:0]      addr_q;

    logic                  arb_en;
    logic                  t_win;
    logic                  c_win;
    logic                  gnt;
    logic                  in_range;
    logic                  cs;
    logic [AddrW-1:0]      win_addr;
    tsmap_owner_e          win_owner;
    logic                  rsp_live;
    logic                  c_rvalid;
    logic                  t_rvalid;

    // Grants are blocked during reset and for the one cycle following it.
    always_comb begin
        arb_en    = !rst_i && !init_q;
        t_win     = arb_en && bus.t_req_i && (!bus.c_req_i || (starve_q == MaxCnt));
        c_win     = arb_en && bus.c_req_i && !t_win;
        gnt       = c_win || t_win;
        win_owner = t_win ? TsOwnTbre : TsOwnCore;
        win_addr  = t_win ? bus.t_addr_i : bus.c_addr_i;
        in_range  = ({1'b0, win_addr} < MapLimit);
        cs        = gnt && in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_q   <= 1'b1;
            starve_q <= '0;
            rsp_q    <= '0;
            addr_q   <= '0;
        end else begin
            init_q <= 1'b0;
            rsp_q  <= '{valid: gnt, owner: win_owner, err: !in_range};
            if (cs) begin
                addr_q <= win_addr;
            end
            if (!bus.t_req_i || t_win) begin
                starve_q <= '0;
            end else if (c_win && (starve_q != MaxCnt)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    // Error replies and the non-owner side see zero data rather than SRAM noise.
    always_comb begin
        rsp_live = rsp_q.valid && !rst_i;
        c_rvalid = rsp_live && (rsp_q.owner == TsOwnCore);
        t_rvalid = rsp_live && (rsp_q.owner == TsOwnTbre);
    end

    assign bus.c_gnt_o        = c_win;
    assign bus.t_gnt_o        = t_win;
    assign bus.tsmap_cs_o     = cs;
    assign bus.tsmap_addr_o   = cs ? win_addr : addr_q;
    assign bus.starve_cnt_o   = starve_q;

    assign bus.c_rvalid_o     = c_rvalid;
    assign bus.c_err_o        = c_rvalid && rsp_q.err;
    assign bus.c_rdata_o      = (c_rvalid && !rsp_q.err) ? bus.tsmap_rdata_i : '0;
    assign bus.c_rdata_intg_o = (c_rvalid && !rsp_q.err) ? bus.tsmap_rdata_intg_i : '0;

    assign bus.t_rvalid_o     = t_rvalid;
    assign bus.t_err_o        = t_rvalid && rsp_q.err;
    assign bus.t_rdata_o      = (t_rvalid && !rsp_q.err) ? bus.tsmap_rdata_i : '0;
    assign bus.t_rdata_intg_o = (t_rvalid && !rsp_q.err) ? bus.tsmap_rdata_intg_i : '0;

endmodule

// File: tb/tb_ibex_tsmap_arb.sv
// Directed bench for ibex_tsmap_arb: reset gating, core reads, contention
// pattern, out-of-range replies, alternation and reset in mid-flight.
module tb_ibex_tsmap_arb;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    ibex_tsmap_arb_if #(.AddrW(16)) bus ();

    ibex_tsmap_arb #(
        .TSMapSize (1024),
        .AddrW     (16),
        .MaxStarve (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic apply_stimulus(input logic r, input logic cr, input logic [15:0] ca,
                                  input logic tr, input logic [15:0] ta,
                                  input logic [31:0] rd, input logic [6:0] ri);
        @(negedge clk);
        rst                    = r;
        bus.c_req_i            = cr;
        bus.c_addr_i           = ca;
        bus.t_req_i            = tr;
        bus.t_addr_i           = ta;
        bus.tsmap_rdata_i      = rd;
        bus.tsmap_rdata_intg_i = ri;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    logic        exp_t;
    logic        prev_t;
    logic [15:0] t_addr_now;
    logic [15:0] c_addr_now;

    initial begin
        compared               = 0;
        mismatched             = 0;
        rst                    = 1'b1;
        bus.c_req_i            = 1'b0;
        bus.c_addr_i           = '0;
        bus.t_req_i            = 1'b0;
        bus.t_addr_i           = '0;
        bus.tsmap_rdata_i      = '0;
        bus.tsmap_rdata_intg_i = '0;

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, 16'h0010, 1, 16'h0020, 32'hFFFF_FFFF, 7'h7F);
            check_output("rst_c_gnt", bus.c_gnt_o, 0);
            check_output("rst_t_gnt", bus.t_gnt_o, 0);
            check_output("rst_cs", bus.tsmap_cs_o, 0);
            check_output("rst_c_rvalid", bus.c_rvalid_o, 0);
            check_output("rst_t_rvalid", bus.t_rvalid_o, 0);
            check_output("rst_c_rdata", bus.c_rdata_o, 0);
            check_output("rst_starve", bus.starve_cnt_o, 0);
        end

        // First cycle out of reset still grants nothing.
        apply_stimulus(0, 1, 16'h0010, 0, 16'h0000, 32'h0, 7'h0);
        check_output("init_c_gnt", bus.c_gnt_o, 0);
        check_output("init_cs", bus.tsmap_cs_o, 0);
        check_output("init_c_rvalid", bus.c_rvalid_o, 0);
        check_output("init_starve", bus.starve_cnt_o, 0);

        apply_stimulus(0, 1, 16'h0010, 0, 16'h0000, 32'h0, 7'h0);
        check_output("rd_c_gnt", bus.c_gnt_o, 1);
        check_output("rd_t_gnt", bus.t_gnt_o, 0);
        check_output("rd_cs", bus.tsmap_cs_o, 1);
        check_output("rd_addr", bus.tsmap_addr_o, 16'h0010);

        apply_stimulus(0, 0, 16'h0000, 0, 16'h0000, 32'hDEAD_BEEF, 7'h2A);
        check_output("rd_c_rvalid", bus.c_rvalid_o, 1);
        check_output("rd_c_rdata", bus.c_rdata_o, 32'hDEAD_BEEF);
        check_output("rd_c_intg", bus.c_rdata_intg_o, 7'h2A);
        check_output("rd_c_err", bus.c_err_o, 0);
        check_output("rd_t_rvalid", bus.t_rvalid_o, 0);
        check_output("rd_t_rdata", bus.t_rdata_o, 0);
        check_output("rd_idle_cs", bus.tsmap_cs_o, 0);
        check_output("rd_addr_hold", bus.tsmap_addr_o, 16'h0010);

        // Continuous contention: expected grant order C,C,C,C,T,C,C,C,C,T.
        prev_t = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_t      = (i == 4) || (i == 9);
            t_addr_now = (i < 5) ? 16'h0200 : 16'h0204;
            c_addr_now = 16'h0100 + 16'(i);
            apply_stimulus(0, 1, c_addr_now, 1, t_addr_now, 32'h1000_0000 + 32'(i), 7'(i));
            check_output($sformatf("ct%0d_c_gnt", i), bus.c_gnt_o, !exp_t);
            check_output($sformatf("ct%0d_t_gnt", i), bus.t_gnt_o, exp_t);
            check_output($sformatf("ct%0d_cs", i), bus.tsmap_cs_o, 1);
            check_output($sformatf("ct%0d_addr", i), bus.tsmap_addr_o,
                         exp_t ? t_addr_now : c_addr_now);
            check_output($sformatf("ct%0d_starve", i), bus.starve_cnt_o, i % 5);
            if (i == 0) begin
                check_output("ct0_c_rvalid", bus.c_rvalid_o, 0);
                check_output("ct0_t_rvalid", bus.t_rvalid_o, 0);
            end else begin
                check_output($sformatf("ct%0d_c_rvalid", i), bus.c_rvalid_o, !prev_t);
                check_output($sformatf("ct%0d_t_rvalid", i), bus.t_rvalid_o, prev_t);
                check_output($sformatf("ct%0d_c_rdata", i), bus.c_rdata_o,
                             prev_t ? 32'h0 : 32'h1000_0000 + 32'(i));
                check_output($sformatf("ct%0d_t_rdata", i), bus.t_rdata_o,
                             prev_t ? 32'h1000_0000 + 32'(i) : 32'h0);
            end
            prev_t = exp_t;
        end

        apply_stimulus(0, 0, 16'h0000, 0, 16'h0000, 32'h1000_000A, 7'h0A);
        check_output("ct_tail_t_rvalid", bus.t_rvalid_o, 1);
        check_output("ct_tail_t_rdata", bus.t_rdata_o, 32'h1000_000A);
        check_output("ct_tail_c_rvalid", bus.c_rvalid_o, 0);
        check_output("ct_tail_cs", bus.tsmap_cs_o, 0);
        check_output("ct_tail_addr", bus.tsmap_addr_o, 16'h0204);
        check_output("ct_tail_starve", bus.starve_cnt_o, 0);

        apply_stimulus(0, 0, 16'h0000, 1, 16'd1024, 32'h0, 7'h0);
        check_output("oor_t_gnt", bus.t_gnt_o, 1);
        check_output("oor_c_gnt", bus.c_gnt_o, 0);
        check_output("oor_cs", bus.tsmap_cs_o, 0);
        check_output("oor_addr_hold", bus.tsmap_addr_o, 16'h0204);

        apply_stimulus(0, 0, 16'h0000, 1, 16'd1023, 32'hFFFF_FFFF, 7'h7F);
        check_output("oor_t_rvalid", bus.t_rvalid_o, 1);
        check_output("oor_t_err", bus.t_err_o, 1);
        check_output("oor_t_rdata", bus.t_rdata_o, 0);
        check_output("oor_t_intg", bus.t_rdata_intg_o, 0);
        check_output("last_t_gnt", bus.t_gnt_o, 1);
        check_output("last_cs", bus.tsmap_cs_o, 1);
        check_output("last_addr", bus.tsmap_addr_o, 16'd1023);

        apply_stimulus(0, 0, 16'h0000, 0, 16'h0000, 32'hCAFE_F00D, 7'h15);
        check_output("last_t_rvalid", bus.t_rvalid_o, 1);
        check_output("last_t_err", bus.t_err_o, 0);
        check_output("last_t_rdata", bus.t_rdata_o, 32'hCAFE_F00D);
        check_output("last_t_intg", bus.t_rdata_intg_o, 7'h15);
        check_output("last_c_rvalid", bus.c_rvalid_o, 0);

        apply_stimulus(0, 1, 16'h0030, 1, 16'h0040, 32'h0, 7'h0);
        check_output("alt1_c_gnt", bus.c_gnt_o, 1);
        check_output("alt1_t_gnt", bus.t_gnt_o, 0);
        check_output("alt1_addr", bus.tsmap_addr_o, 16'h0030);

        apply_stimulus(0, 0, 16'h0000, 1, 16'h0040, 32'h1111_1111, 7'h01);
        check_output("alt2_t_gnt", bus.t_gnt_o, 1);
        check_output("alt2_addr", bus.tsmap_addr_o, 16'h0040);
        check_output("alt2_starve", bus.starve_cnt_o, 1);
        check_output("alt2_c_rvalid", bus.c_rvalid_o, 1);
        check_output("alt2_c_rdata", bus.c_rdata_o, 32'h1111_1111);
        check_output("alt2_t_rvalid", bus.t_rvalid_o, 0);

        apply_stimulus(0, 0, 16'h0000, 0, 16'h0000, 32'h2222_2222, 7'h02);
        check_output("alt3_t_rvalid", bus.t_rvalid_o, 1);
        check_output("alt3_t_rdata", bus.t_rdata_o, 32'h2222_2222);
        check_output("alt3_c_rvalid", bus.c_rvalid_o, 0);
        check_output("alt3_c_rdata", bus.c_rdata_o, 0);
        check_output("alt3_starve", bus.starve_cnt_o, 0);

        apply_stimulus(0, 0, 16'h0000, 1, 16'h0050, 32'h0, 7'h0);
        check_output("mr_t_gnt", bus.t_gnt_o, 1);
        check_output("mr_cs", bus.tsmap_cs_o, 1);

        apply_stimulus(1, 1, 16'h0060, 1, 16'h0070, 32'h3333_3333, 7'h33);
        check_output("mr_rst_t_rvalid", bus.t_rvalid_o, 0);
        check_output("mr_rst_t_rdata", bus.t_rdata_o, 0);
        check_output("mr_rst_c_gnt", bus.c_gnt_o, 0);
        check_output("mr_rst_t_gnt", bus.t_gnt_o, 0);
        check_output("mr_rst_cs", bus.tsmap_cs_o, 0);

        apply_stimulus(0, 1, 16'h0060, 1, 16'h0070, 32'h4444_4444, 7'h44);
        check_output("mr_init_t_rvalid", bus.t_rvalid_o, 0);
        check_output("mr_init_c_gnt", bus.c_gnt_o, 0);
        check_output("mr_init_t_gnt", bus.t_gnt_o, 0);
        check_output("mr_init_starve", bus.starve_cnt_o, 0);

        apply_stimulus(0, 1, 16'h0060, 1, 16'h0070, 32'h5555_5555, 7'h55);
        check_output("mr_g1_c_gnt", bus.c_gnt_o, 1);
        check_output("mr_g1_addr", bus.tsmap_addr_o, 16'h0060);
        check_output("mr_g1_starve", bus.starve_cnt_o, 0);
        check_output("mr_g1_c_rvalid", bus.c_rvalid_o, 0);

        apply_stimulus(0, 1, 16'h0060, 1, 16'h0070, 32'h6666_6666, 7'h66);
        check_output("mr_g2_c_gnt", bus.c_gnt_o, 1);
        check_output("mr_g2_starve", bus.starve_cnt_o, 1);
        check_output("mr_g2_c_rvalid", bus.c_rvalid_o, 1);
        check_output("mr_g2_c_rdata", bus.c_rdata_o, 32'h6666_6666);

        // Counter is synchronous: still visible during the reset cycle itself.
        apply_stimulus(1, 1, 16'h0060, 1, 16'h0070, 32'h7777_7777, 7'h77);
        check_output("mr2_rst_starve", bus.starve_cnt_o, 2);
        check_output("mr2_rst_c_gnt", bus.c_gnt_o, 0);
        check_output("mr2_rst_c_rvalid", bus.c_rvalid_o, 0);
        check_output("mr2_rst_c_rdata", bus.c_rdata_o, 0);

        apply_stimulus(0, 0, 16'h0000, 0, 16'h0000, 32'h0, 7'h0);
        check_output("mr2_post_starve", bus.starve_cnt_o, 0);
        check_output("mr2_post_c_gnt", bus.c_gnt_o, 0);
        check_output("mr2_post_t_gnt", bus.t_gnt_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
